// File: rtl/mem_responder.sv
// Memory-side responder: accepts one Read/Write request at a time, waits
// WAIT_CYCLES, performs a single word access on an internal RAM and pulses mem_ready.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_ILL} req_e;

  logic [DATA_W-1:0] ram [DEPTH];

  state_e            state_q, state_d;
  req_e              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              ram_we;

  // Next-state and access control
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Read || Write) begin
          addr_d  = MAR_addr;
          wdata_d = MDR_wdata;
          if (Read && Write) req_d = REQ_ILL;
          else if (Read)     req_d = REQ_RD;
          else               req_d = REQ_WR;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          case (req_q)
            REQ_RD:  rdata_d = ram[addr_q];
            REQ_WR:  ram_we  = 1'b1;
            default: err_d   = 1'b1;
          endcase
          ready_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      req_q   <= REQ_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a reset forces IDLE so no write can slip through
  always_ff @(posedge clock) begin
    if (ram_we) ram[addr_q] <= wdata_q;
  end

  assign Mdatain   = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed and random transactions on a 2-wait-state
// and a 0-wait-state instance, checked against an array-based memory model.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  bit          sel = 1'b0;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance

  logic [31:0] d2_mdat, d0_mdat;
  logic        d2_rdy, d0_rdy, d2_busy, d0_busy, d2_err, d0_err;
  logic [31:0] mdat;
  logic        rdy, busy, err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m  [2][512];
  bit          valid_m[2][512];
  logic [31:0] exp_md [2];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) dut2 (
    .clock(clk), .clear(clear), .Read(rd & ~sel), .Write(wr & ~sel),
    .MAR_addr(addr), .MDR_wdata(wdata),
    .Mdatain(d2_mdat), .mem_ready(d2_rdy), .mem_busy(d2_busy), .mem_err(d2_err));

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .clear(clear), .Read(rd & sel), .Write(wr & sel),
    .MAR_addr(addr), .MDR_wdata(wdata),
    .Mdatain(d0_mdat), .mem_ready(d0_rdy), .mem_busy(d0_busy), .mem_err(d0_err));

  assign mdat = sel ? d0_mdat : d2_mdat;
  assign rdy  = sel ? d0_rdy  : d2_rdy;
  assign busy = sel ? d0_busy : d2_busy;
  assign err  = sel ? d0_err  : d2_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (inst %0d): got %h expected %h", tag, sel ? 0 : 2, obs, exp);
    end
  endtask

  // One transaction; optionally a write to a+1 is attempted while it is pending.
  task automatic txn(input bit r, input bit w, input logic [8:0] a,
                     input logic [31:0] d, input bit drop);
    int n;
    int wc;
    bit ill;
    wc  = sel ? 0 : 2;
    ill = r && w;
    n   = 0;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    if (drop) begin
      wr = 1'b1; addr = a + 9'd1; wdata = ~d;
    end
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (drop && n == 1) wr = 1'b0;
      if (rdy) break;
    end
    check("ready_latency", 32'(n), 32'(wc + 1));
    if (!ill) begin
      if (r) exp_md[sel] = mem_m[sel][a];
      else begin
        mem_m[sel][a]   = d;
        valid_m[sel][a] = 1'b1;
      end
    end
    check("err_with_ready", 32'(err), 32'(ill));
    check("mdatain", mdat, exp_md[sel]);
    check("busy_in_resp", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("ready_falls", 32'(rdy), 32'd0);
    check("err_falls", 32'(err), 32'd0);
    check("busy_falls", 32'(busy), 32'd0);
    if (drop) begin
      repeat (4) begin
        @(posedge clk); #1;
        check("no_dropped_ready", 32'(rdy), 32'd0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mdat2"}, d2_mdat, 32'd0);
    check({tag, "_mdat0"}, d0_mdat, 32'd0);
    check({tag, "_flags"}, {28'd0, d2_rdy, d2_busy, d0_rdy | d0_err, d2_err | d0_busy}, 32'd0);
  endtask

  task automatic random_txns(input int count);
    int op;
    logic [8:0] a;
    for (int i = 0; i < count; i++) begin
      op = int'($urandom_range(0, 9));
      a  = 9'h100 + 9'($urandom_range(0, 15));
      if (op < 4 && valid_m[sel][a]) txn(1'b1, 1'b0, a, $urandom, 1'b0);
      else if (op < 9)               txn(1'b0, 1'b1, a, $urandom, 1'b0);
      else                           txn(1'b1, 1'b1, a, $urandom, 1'b0);
    end
  endtask

  initial begin
    exp_md[0] = '0;
    exp_md[1] = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    clear = 1'b1;

    // WAIT_CYCLES=2 instance
    sel = 1'b0;
    txn(1'b0, 1'b1, 9'h005, 32'hA5A5_0005, 1'b0);
    txn(1'b0, 1'b1, 9'h003, 32'h3333_0003, 1'b0);
    txn(1'b0, 1'b1, 9'h007, 32'h7777_0007, 1'b0);
    txn(1'b0, 1'b1, 9'h001, 32'h1111_0001, 1'b0);
    txn(1'b0, 1'b1, 9'h002, 32'h2222_0002, 1'b0);
    txn(1'b1, 1'b0, 9'h005, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 9'h012, 32'h0000_0014, 1'b0);
    txn(1'b1, 1'b0, 9'h012, 32'h0, 1'b0);
    txn(1'b1, 1'b1, 9'h003, 32'hFFFF_FFFF, 1'b0);
    txn(1'b1, 1'b0, 9'h003, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 9'h001, 32'h0, 1'b1);
    txn(1'b1, 1'b0, 9'h002, 32'h0, 1'b0);

    // Reset while a write is waiting: outputs clear at once and the write is lost
    @(negedge clk);
    wr = 1'b1; addr = 9'h007; wdata = 32'h0000_0018;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #2;
    clear = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_md[0] = '0;
    exp_md[1] = '0;
    @(negedge clk);
    clear = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("no_ready_after_abort", 32'(rdy), 32'd0);
    end
    txn(1'b1, 1'b0, 9'h007, 32'h0, 1'b0);
    random_txns(40);

    // WAIT_CYCLES=0 instance
    sel = 1'b1;
    txn(1'b0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 1'b0);
    txn(1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);
    @(negedge clk);
    rd = 1'b1; addr = 9'h1FF;
    exp_md[1] = mem_m[1][9'h1FF];
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 10) rd = 1'b0;
      check("held_read_ready", 32'(rdy), 32'((i % 3) == 1));
      check("held_read_busy", 32'(busy), 32'((i % 3) != 2));
      if (rdy) check("held_read_data", mdat, exp_md[1]);
    end
    random_txns(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
